// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: one-hot game FSM state codes,
// the sequencer's internal phase encoding and the debug view struct.
package game_pkg;

  // One-hot game FSM states, packed as {q_start, q_playing, q_lose, q_win}
  localparam logic [3:0] WIN     = 4'b0001;
  localparam logic [3:0] LOSE    = 4'b0010;
  localparam logic [3:0] PLAYING = 4'b0100;
  localparam logic [3:0] START   = 4'b1000;

  localparam int LIVES_W = 3;
  localparam int TIME_W  = 7;

  // Sequencer round phase
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } phase_t;

  // Debug view: internal phase plus the game FSM state it is reacting to
  typedef struct packed {
    phase_t     phase;
    logic [3:0] fsm_state;
  } seq_dbg_t;

  // True when the one-hot game FSM state has the bit of 'which' set
  function automatic logic fsm_in(input logic [3:0] state, input logic [3:0] which);
    return |(state & which);
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Button debouncer: 2-flop synchronizer, stable-count filter and a registered
// one-cycle pulse on each stable 0->1 transition. Latency from a clean rise
// to the pulse is DEB_CYCLES+3 cycles.
module btn_debouncer #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn_raw,
  output logic o_pulse
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;

  // Bring the asynchronous button into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Flip the stable level only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (r_sync2 != r_stable) begin
      if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // Registered rising-edge detect on the stable level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable_d <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
      r_pulse    <= r_stable & ~r_stable_d;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: debounces the start button, tracks score/lives/countdown
// during a round and issues exactly one win or lose pulse per round.
// Optional pause support is built when GAME_SEQ_PAUSE_EN is defined.
//
// Handshake note: hit/miss are single-cycle strobes with no backpressure;
// a strobe counts only in a cycle where the round is actively running.
module game_sequencer
  import game_pkg::*;
#(
  parameter int TICK_CYCLES   = 100_000_000,
  parameter int ROUND_SECONDS = 60,
  parameter int START_LIVES   = 3,
  parameter int WIN_SCORE     = 10,
  parameter int SCORE_W       = 8,
  parameter int DEB_CYCLES    = 500_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_raw,
  input  logic               hit,
  input  logic               miss,
  input  logic               q_start,
  input  logic               q_playing,
  input  logic               q_lose,
  input  logic               q_win,
  output logic               start_pulse,
  output logic               win,
  output logic               lose,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic [TIME_W-1:0]  time_left,
  output logic               sec_tick,
`ifdef GAME_SEQ_PAUSE_EN
  input  logic               pause_btn_raw,
  output logic               paused,
`endif
  output seq_dbg_t           dbg
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
  localparam logic [TIME_W-1:0]  TIME_INIT  = TIME_W'(ROUND_SECONDS);

  phase_t             r_phase;
  phase_t             w_phase_next;
  logic [3:0]         w_fsm_state;
  logic               w_go_idle;
  logic               w_go_play;
  logic               w_win_cond;
  logic               w_lose_cond;
  logic               w_win_next;
  logic               w_lose_next;
  logic               w_count_en;
  logic               w_tick_wrap;
  logic               w_paused;
  logic               r_win;
  logic               r_lose;
  logic               r_sec_tick;
  logic [TICK_W-1:0]  r_tick;
  logic [SCORE_W-1:0] r_score;
  logic [LIVES_W-1:0] r_lives;
  logic [TIME_W-1:0]  r_time_left;

  assign w_fsm_state = {q_start, q_playing, q_lose, q_win};
  assign w_go_idle   = fsm_in(w_fsm_state, START);
  assign w_go_play   = fsm_in(w_fsm_state, PLAYING);

  // Start button conditioning
  btn_debouncer #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_start_deb (
    .clk       (clk),
    .reset     (reset),
    .i_btn_raw (btn_raw),
    .o_pulse   (start_pulse)
  );

`ifdef GAME_SEQ_PAUSE_EN
  logic w_pause_pulse;
  logic r_paused;

  // Pause button conditioning
  btn_debouncer #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_pause_deb (
    .clk       (clk),
    .reset     (reset),
    .i_btn_raw (pause_btn_raw),
    .o_pulse   (w_pause_pulse)
  );

  // Pause toggles only while a round runs and always clears back in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_paused <= 1'b0;
    end else if (r_phase == IDLE || w_phase_next == IDLE) begin
      r_paused <= 1'b0;
    end else if (w_pause_pulse && r_phase == RUN) begin
      r_paused <= ~r_paused;
    end
  end

  assign w_paused = r_paused;
  assign paused   = r_paused;
`else
  assign w_paused = 1'b0;
`endif

  // Round-end conditions are judged on the registered counters
  assign w_win_cond  = (r_score == SCORE_WIN);
  assign w_lose_cond = (r_lives == '0) || (r_time_left == '0);

  // Phase register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= IDLE;
    end else begin
      r_phase <= w_phase_next;
    end
  end

  // Next phase and round-end pulse decode; win has priority over lose
  always_comb begin
    w_phase_next = r_phase;
    w_win_next   = 1'b0;
    w_lose_next  = 1'b0;
    if (w_go_idle) begin
      w_phase_next = IDLE;
    end else begin
      case (r_phase)
        IDLE: begin
          if (w_go_play) begin
            w_phase_next = RUN;
          end
        end
        RUN: begin
          if (!w_paused) begin
            if (w_win_cond) begin
              w_win_next   = 1'b1;
              w_phase_next = DONE;
            end else if (w_lose_cond) begin
              w_lose_next  = 1'b1;
              w_phase_next = DONE;
            end
          end
        end
        DONE: begin
          w_phase_next = DONE;
        end
        default: begin
          w_phase_next = IDLE;
        end
      endcase
    end
  end

  // Counters advance only in a live, unpaused round that is not ending now
  assign w_count_en  = (r_phase == RUN) && !w_go_idle && !w_paused &&
                       !w_win_cond && !w_lose_cond;
  assign w_tick_wrap = w_count_en && (r_tick == TICK_LAST);

  // Registered win/lose pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win  <= 1'b0;
      r_lose <= 1'b0;
    end else begin
      r_win  <= w_win_next;
      r_lose <= w_lose_next;
    end
  end

  // Score, lives, countdown and tick counter; reloaded in IDLE, frozen in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick      <= '0;
      r_sec_tick  <= 1'b0;
      r_score     <= '0;
      r_lives     <= LIVES_INIT;
      r_time_left <= TIME_INIT;
    end else if (r_phase == IDLE || w_go_idle) begin
      r_tick      <= '0;
      r_sec_tick  <= 1'b0;
      r_score     <= '0;
      r_lives     <= LIVES_INIT;
      r_time_left <= TIME_INIT;
    end else begin
      r_sec_tick <= w_tick_wrap;
      if (w_count_en) begin
        r_tick <= w_tick_wrap ? '0 : r_tick + TICK_W'(1);
        if (w_tick_wrap && r_time_left != '0) begin
          r_time_left <= r_time_left - TIME_W'(1);
        end
        if (hit && r_score != SCORE_WIN) begin
          r_score <= r_score + SCORE_W'(1);
        end
        if (miss && r_lives != '0) begin
          r_lives <= r_lives - LIVES_W'(1);
        end
      end
    end
  end

  assign win       = r_win;
  assign lose      = r_lose;
  assign sec_tick  = r_sec_tick;
  assign score     = r_score;
  assign lives     = r_lives;
  assign time_left = r_time_left;

  assign dbg.phase     = r_phase;
  assign dbg.fsm_state = w_fsm_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with small parameters
// (TICK=4, ROUND=3, LIVES=2, WIN=2, DEB=3). Inputs change on the falling
// edge; outputs are checked on the falling edge.
module tb_game_sequencer;
  import game_pkg::*;

  localparam int TICK_CYCLES   = 4;
  localparam int ROUND_SECONDS = 3;
  localparam int START_LIVES   = 2;
  localparam int WIN_SCORE     = 2;
  localparam int SCORE_W       = 8;
  localparam int DEB_CYCLES    = 3;

  logic               clk;
  logic               reset;
  logic               btn_raw;
  logic               hit;
  logic               miss;
  logic               q_start;
  logic               q_playing;
  logic               q_lose;
  logic               q_win;
  logic               start_pulse;
  logic               win;
  logic               lose;
  logic [SCORE_W-1:0] score;
  logic [2:0]         lives;
  logic [6:0]         time_left;
  logic               sec_tick;
  seq_dbg_t           dbg;
`ifdef GAME_SEQ_PAUSE_EN
  logic               pause_btn_raw;
  logic               paused;
`endif

  int n_tests;
  int n_fail;
  logic [6:0] exp_q[$];

  game_sequencer #(
    .TICK_CYCLES   (TICK_CYCLES),
    .ROUND_SECONDS (ROUND_SECONDS),
    .START_LIVES   (START_LIVES),
    .WIN_SCORE     (WIN_SCORE),
    .SCORE_W       (SCORE_W),
    .DEB_CYCLES    (DEB_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .hit           (hit),
    .miss          (miss),
    .q_start       (q_start),
    .q_playing     (q_playing),
    .q_lose        (q_lose),
    .q_win         (q_win),
    .start_pulse   (start_pulse),
    .win           (win),
    .lose          (lose),
    .score         (score),
    .lives         (lives),
    .time_left     (time_left),
    .sec_tick      (sec_tick),
`ifdef GAME_SEQ_PAUSE_EN
    .pause_btn_raw (pause_btn_raw),
    .paused        (paused),
`endif
    .dbg           (dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver helpers
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic enter_idle();
    q_playing = 1'b0;
    q_start   = 1'b1;
    step(1);
    check("idle_phase", 32'(dbg.phase), 32'(IDLE));
    check("idle_score", 32'(score), 0);
    check("idle_lives", 32'(lives), START_LIVES);
    check("idle_time", 32'(time_left), ROUND_SECONDS);
    q_start = 1'b0;
  endtask

  // Runs a winning round; called on the first RUN cycle (c0)
  task automatic play_win_round(input string tag);
    check({tag, "_run"}, 32'(dbg.phase), 32'(RUN));
    check({tag, "_score0"}, 32'(score), 0);
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    check({tag, "_score1"}, 32'(score), 1);
    step(2);
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    check({tag, "_score2"}, 32'(score), 2);
    check({tag, "_win_early"}, 32'(win), 0);
    step(1);
    check({tag, "_win"}, 32'(win), 1);
    check({tag, "_lose0"}, 32'(lose), 0);
    check({tag, "_done"}, 32'(dbg.phase), 32'(DONE));
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    check({tag, "_win_once"}, 32'(win), 0);
    check({tag, "_score_frozen"}, 32'(score), 2);
    step(4);
    check({tag, "_time_frozen"}, 32'(time_left), 2);
    check({tag, "_no_lose"}, 32'(lose), 0);
  endtask

  initial begin
    int pulses;
    int loses;
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    btn_raw   = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;
    q_start   = 1'b0;
    q_playing = 1'b0;
    q_lose    = 1'b0;
    q_win     = 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
    pause_btn_raw = 1'b0;
`endif

    // Reset values
    step(2);
    check("rst_start_pulse", 32'(start_pulse), 0);
    check("rst_win", 32'(win), 0);
    check("rst_lose", 32'(lose), 0);
    check("rst_sec_tick", 32'(sec_tick), 0);
    check("rst_score", 32'(score), 0);
    check("rst_lives", 32'(lives), START_LIVES);
    check("rst_time", 32'(time_left), ROUND_SECONDS);
    check("rst_phase", 32'(dbg.phase), 32'(IDLE));
    reset = 1'b0;
    step(2);

    // 1: bounce 1,0,1 then hold; single pulse 6 edges after the final rise
    btn_raw = 1'b1;
    step(1);
    btn_raw = 1'b0;
    step(1);
    btn_raw = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (start_pulse) pulses++;
      check("deb_pulse", 32'(start_pulse), (k == DEB_CYCLES + 3) ? 1 : 0);
    end
    check("deb_pulse_count", 32'(pulses), 1);
    btn_raw = 1'b0;
    step(8);
    check("deb_release_no_pulse", 32'(start_pulse), 0);

    // 2: win round
    q_playing = 1'b1;
    step(1);
    play_win_round("win");
    enter_idle();

    // 3: timeout round
    exp_q.push_back(7'd2);
    exp_q.push_back(7'd1);
    exp_q.push_back(7'd0);
    q_playing = 1'b1;
    step(1);
    check("to_time0", 32'(time_left), ROUND_SECONDS);
    loses = 0;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      check("to_sec_tick", 32'(sec_tick), (k == 4 || k == 8 || k == 12) ? 1 : 0);
      if (sec_tick) begin
        if (exp_q.size() == 0) begin
          check("to_extra_tick", 32'(exp_q.size()), 1);
        end else begin
          check("to_time_left", 32'(time_left), 32'(exp_q.pop_front()));
        end
      end
      if (lose) loses++;
      check("to_lose", 32'(lose), (k == 13) ? 1 : 0);
      check("to_win", 32'(win), 0);
    end
    check("to_queue_empty", 32'(exp_q.size()), 0);
    check("to_lose_count", 32'(loses), 1);
    enter_idle();

    // 4: hit and miss together at score=1, lives=1
    q_playing = 1'b1;
    step(1);
    hit  = 1'b1;
    miss = 1'b1;
    step(1);
    check("hm_score1", 32'(score), 1);
    check("hm_lives1", 32'(lives), 1);
    step(1);
    hit  = 1'b0;
    miss = 1'b0;
    check("hm_score2", 32'(score), 2);
    check("hm_lives0", 32'(lives), 0);
    step(1);
    check("hm_win", 32'(win), 1);
    check("hm_lose", 32'(lose), 0);
    step(1);
    check("hm_win_once", 32'(win), 0);
    check("hm_lose_after", 32'(lose), 0);
    enter_idle();

    // 5: async reset mid-round, then a fresh winning round
    q_playing = 1'b1;
    step(1);
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    check("mr_score1", 32'(score), 1);
    #2 reset = 1'b1;
    #1;
    check("mr_score", 32'(score), 0);
    check("mr_lives", 32'(lives), START_LIVES);
    check("mr_time", 32'(time_left), ROUND_SECONDS);
    check("mr_phase", 32'(dbg.phase), 32'(IDLE));
    check("mr_win", 32'(win), 0);
    step(1);
    reset = 1'b0;
    step(1);
    play_win_round("rw");
    enter_idle();

`ifdef GAME_SEQ_PAUSE_EN
    // 6: pause freezes the countdown and ignores hits; second press resumes
    q_playing = 1'b1;
    step(1);
    check("pz_init", 32'(paused), 0);
    pause_btn_raw = 1'b1;
    step(DEB_CYCLES + 4);
    check("pz_on", 32'(paused), 1);
    begin
      logic [6:0] held;
      held = time_left;
      hit = 1'b1;
      step(1);
      hit = 1'b0;
      step(10);
      check("pz_time_hold", 32'(time_left), 32'(held));
      check("pz_hit_ignored", 32'(score), 0);
      check("pz_no_lose", 32'(lose), 0);
      pause_btn_raw = 1'b0;
      step(DEB_CYCLES + 4);
      check("pz_still_on", 32'(paused), 1);
      pause_btn_raw = 1'b1;
      step(DEB_CYCLES + 4);
      check("pz_off", 32'(paused), 0);
      step(5);
      check("pz_resumed", 32'(time_left), 32'(held - 7'd1));
      pause_btn_raw = 1'b0;
    end
    enter_idle();
    check("pz_idle_clear", 32'(paused), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
